j1_uart_rx: RTL and testbench

Receive-side UART front end for the J1 core: oversamples the asynchronous `rx` pin, deframes 8N1 characters, and queues received bytes in a small FIFO drained by the core's I/O read path. It sits directly upstream of the core's UART input, between the pad (`io_in[25]`) and the J1 I/O bus. It absorbs burst traffic while the Forth core is busy, and reports framing and overrun errors as sticky flags.

---
 rtl/j1_uart_rx.sv | 230 +++++++++++++++++++++++
 tb/tb_j1_uart_rx.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/j1_uart_rx.sv
// j1_uart_rx -- receive-side UART front end for the J1 core.
//
// Oversamples the asynchronous rx pin, deframes 8N1 characters (8E1 when
// J1_UART_RX_PARITY_EN is defined) and queues received bytes in a small
// circular FIFO that the core drains through its I/O read path.
//
// Build option:
//   J1_UART_RX_PARITY_EN  defined   -> 8E1 frames, even parity checked;
//                                      a parity mismatch raises frameErr.
//                         undefined -> 8N1 frames, no parity state.
//
// Ports:
//   boardClk   in   system clock, rising edge
//   resetN     in   asynchronous active-low reset
//   rx         in   asynchronous serial input, idles high
//   rdata      out  [7:0] byte at FIFO head (valid while rvalid)
//   rvalid     out  FIFO not empty
//   rready     in   pop request; pop when rvalid && rready
//   count      out  [DEPTH_LOG2:0] FIFO fill level
//   frameErr   out  sticky: bad stop bit (or bad parity)
//   overrun    out  sticky: byte dropped because FIFO was full
//   errClr     in   pulse clearing both sticky flags (a set event wins)
module j1_uart_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DEPTH_LOG2   = 3
) (
  input  logic                  boardClk,
  input  logic                  resetN,
  input  logic                  rx,
  output logic [7:0]            rdata,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  frameErr,
  output logic                  overrun,
  input  logic                  errClr
);

  localparam int TW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  // The timer counts down to zero; the sample happens on the zero cycle,
  // so a wait of N cycles loads N-1.
  localparam logic [TW-1:0]       BIT_LD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]       HALF_LD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [DEPTH_LOG2:0] FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef J1_UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  logic                  sync1_q, sync1_d;
  logic                  rxs_q, rxs_d;
  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
`ifdef J1_UART_RX_PARITY_EN
  logic                  par_q, par_d;
`endif

  logic tick, push, frame_set, par_err;
  logic pop, full, wr_en, ovr_set;

  always_comb begin
    sync1_d   = rx;
    rxs_d     = sync1_q;
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    tick      = (timer_q == '0);
`ifdef J1_UART_RX_PARITY_EN
    par_d     = par_q;
    // Even parity: data plus parity bit must hold an even number of ones.
    par_err   = ^{shift_q, par_q};
`else
    par_err   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          timer_d = HALF_LD;
        end
      end
      S_START: begin
        if (tick) begin
          timer_d   = BIT_LD;
          bit_cnt_d = '0;
          // Line back high at mid-start-bit means a glitch, not a start.
          state_d   = rxs_q ? S_IDLE : S_DATA;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          timer_d   = BIT_LD;
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef J1_UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
`ifdef J1_UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          timer_d = BIT_LD;
          par_d   = rxs_q;
          state_d = S_STOP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          timer_d = BIT_LD;
          if (rxs_q) begin
            // Leaving at mid-stop-bit lets a following start bit be caught.
            push      = !par_err;
            frame_set = par_err;
            state_d   = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_BREAK;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_BREAK: begin
        // Hold here until the line recovers so a long break flags once.
        if (rxs_q) begin
          state_d = S_IDLE;
          timer_d = BIT_LD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // FIFO bookkeeping. A pop frees a slot in the same cycle, so a push
    // into a full FIFO alongside a pop is accepted.
    pop      = (count_q != '0) && rready;
    full     = (count_q == FULL);
    wr_en    = push && (!full || pop);
    ovr_set  = push && full && !pop;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    frame_err_d = frame_set | (frame_err_q & ~errClr);
    overrun_d   = ovr_set   | (overrun_q   & ~errClr);
  end

  always_ff @(posedge boardClk or negedge resetN) begin
    if (!resetN) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= S_IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef J1_UART_RX_PARITY_EN
      par_q       <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      sync1_q     <= sync1_d;
      rxs_q       <= rxs_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef J1_UART_RX_PARITY_EN
      par_q       <= par_d;
`endif
      if (wr_en) begin
        mem[wr_ptr_q] <= shift_q;
      end
    end
  end

  assign rdata    = mem[rd_ptr_q];
  assign rvalid   = (count_q != '0);
  assign count    = count_q;
  assign frameErr = frame_err_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_j1_uart_rx.sv
// Self-checking bench for j1_uart_rx (CLKS_PER_BIT=8, DEPTH_LOG2=3).
// Expected FIFO contents and flags come from a queue-based model of the
// line protocol; all stimulus and sampling happens on the falling edge.
module tb_j1_uart_rx;
  localparam int CPB   = 8;
  localparam int DL    = 3;
  localparam int DEPTH = 1 << DL;
`ifdef J1_UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Rising edge (counted from the start-bit drive) carrying the stop sample.
  localparam int PUSH_EDGE = 3 + CPB / 2 + CPB * (NB - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic rready = 1'b0;
  logic err_clr = 1'b0;
  logic [7:0] rdata;
  logic rvalid, frame_err, overrun;
  logic [DL:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovr;

  always #5 clk = ~clk;

  j1_uart_rx #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL)) dut (
    .boardClk(clk), .resetN(rst_n), .rx(rx), .rdata(rdata), .rvalid(rvalid),
    .rready(rready), .count(count), .frameErr(frame_err), .overrun(overrun),
    .errClr(err_clr)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one whole frame; optionally raises rready for exactly the
  // cycle on which the stop bit is sampled.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit pop_at_push);
    logic fbits [NB];
    int n;
    fbits[0] = 1'b0;
    for (int i = 0; i < 8; i++) fbits[i + 1] = d[i];
`ifdef J1_UART_RX_PARITY_EN
    fbits[9] = ^d;
`endif
    fbits[NB - 1] = stop_bit;
    $display("tx frame data=%02h stop=%b pop_at_push=%0d", d, stop_bit, pop_at_push);
    n = 0;
    for (int i = 0; i < NB; i++) begin
      rx = fbits[i];
      for (int j = 0; j < CPB; j++) begin
        @(negedge clk);
        n++;
        if (pop_at_push) rready = (n == PUSH_EDGE - 1);
      end
    end
  endtask

  task automatic pop_one();
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  // Pops every queued byte, comparing each against the model.
  task automatic drain_check(input string tag);
    while (exp_q.size() > 0) begin
      checks++;
      if (rdata !== exp_q[0] || rvalid !== 1'b1) begin
        errors++;
        $display("FAIL %s_rdata: got %02h (rvalid %b), expected %02h", tag, rdata, rvalid, exp_q[0]);
      end
      $display("rx byte %02h", rdata);
      pop_one();
      void'(exp_q.pop_front());
    end
    checks++;
    if (rvalid !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL %s_empty: got rvalid %b count %0d, expected 0 0", tag, rvalid, count);
    end
  endtask

  task automatic check_count(input string tag);
    checks++;
    if (int'(count) !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d, expected %0d", tag, count, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_ovr = 1'b0;
    idle(200);
    checks++;
    if (rvalid !== 1'b0 || count !== '0 || rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got rvalid %b count %0d rdata %02h, expected 0 0 00", rvalid, count, rdata);
    end
    checks++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got frameErr %b overrun %b, expected 0 0", frame_err, overrun);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'hA5, 1'b1, 0); model_push(8'hA5);
    send_frame(8'h3C, 1'b1, 0); model_push(8'h3C);
    idle(10);
    check_count("b2b_two");
    checks++;
    if (rdata !== exp_q[0]) begin
      errors++;
      $display("FAIL b2b_head: got %02h, expected %02h", rdata, exp_q[0]);
    end
    pop_one();
    void'(exp_q.pop_front());
    check_count("b2b_after_pop");
    checks++;
    if (rdata !== exp_q[0]) begin
      errors++;
      $display("FAIL b2b_next: got %02h, expected %02h", rdata, exp_q[0]);
    end
    drain_check("b2b");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      int n;
      logic [7:0] b;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        send_frame(b, 1'b1, 0);
        model_push(b);
      end
      idle(10);
      check_count("rand");
      drain_check("rand");
    end
  endtask

  task automatic test_glitch();
    logic [7:0] b;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    idle(30);
    check_count("glitch");
    checks++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL glitch_flags: got frameErr %b overrun %b, expected 0 0", frame_err, overrun);
    end
    b = 8'($urandom);
    send_frame(b, 1'b1, 0);
    model_push(b);
    idle(10);
    check_count("glitch_after");
    drain_check("glitch_after");
  endtask

  task automatic test_break();
    send_frame(8'($urandom), 1'b0, 0);
    // Line stays low after the bad stop bit.
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL break_set: got frameErr %b, expected 1", frame_err);
    end
    repeat (5) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL break_clr: got frameErr %b, expected 0", frame_err);
    end
    repeat (34) @(negedge clk);
    idle(20);
    send_frame(8'h55, 1'b1, 0);
    model_push(8'h55);
    idle(10);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL break_single_event: got frameErr %b, expected 0", frame_err);
    end
    check_count("break");
    checks++;
    if (rdata !== 8'h55) begin
      errors++;
      $display("FAIL break_rdata: got %02h, expected 55", rdata);
    end
    drain_check("break");
  endtask

  task automatic test_overrun();
    for (int k = 0; k < 9; k++) begin
      send_frame(8'(k), 1'b1, 0);
      model_push(8'(k));
    end
    idle(10);
    check_count("ovr_full");
    checks++;
    if (overrun !== exp_ovr || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL ovr_flag: got overrun %b frameErr %b, expected %b 0", overrun, frame_err, exp_ovr);
    end
    drain_check("ovr");
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_ovr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clr: got %b, expected 0", overrun);
    end
    // Second pass: a pop coincides with the 9th push.
    for (int k = 0; k < 8; k++) begin
      send_frame(8'(k), 1'b1, 0);
      model_push(8'(k));
    end
    send_frame(8'h08, 1'b1, 1);
    void'(exp_q.pop_front());
    model_push(8'h08);
    idle(10);
    checks++;
    if (overrun !== exp_ovr) begin
      errors++;
      $display("FAIL ovr_pushpop: got overrun %b, expected %b", overrun, exp_ovr);
    end
    check_count("ovr_pushpop");
    drain_check("ovr_pushpop");
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'($urandom);
    send_frame(b, 1'b1, 0);
    model_push(b);
    // Start a second character and cut it off during its data bits.
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      rx = 1'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    exp_q.delete();
    exp_ovr = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || count !== '0 || rdata !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got rvalid %b count %0d rdata %02h frameErr %b overrun %b, expected all 0",
               rvalid, count, rdata, frame_err, overrun);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    send_frame(8'hF0, 1'b1, 0);
    model_push(8'hF0);
    idle(10);
    check_count("midreset_after");
    checks++;
    if (rdata !== 8'hF0) begin
      errors++;
      $display("FAIL midreset_rdata: got %02h, expected f0", rdata);
    end
    drain_check("midreset");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_random();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
